// File: rtl/int_ctrl_p.sv
// Memory-mapped interrupt controller: latches rising edges from NUM_SRC sources,
// masks and prioritises them, and drives one level request with claim/EOI handshake.
module int_ctrl_p #(
   parameter int NUM_SRC = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wea,
   input  logic [3:0]         addra,
   input  logic [31:0]        dina,
   output logic [31:0]        douta,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               int_cpu
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ASSERT,
      ST_SERVICE
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [NUM_SRC-1:0]   pend;
   logic [NUM_SRC-1:0]   mask;
   logic [NUM_SRC-1:0]   prev_src;
   logic [NUM_SRC-1:0]   eligible;
   logic [NUM_SRC-1:0]   edges;
   logic [NUM_SRC-1:0]   w1c_bits;
   logic [NUM_SRC-1:0]   claim_clr;
   logic                 ctrl_en;
   logic                 any_eligible;
   logic                 claim_read;
   logic                 eoi_write;
   logic                 claim_fire;
   logic                 int_cpu_next;
   logic [3:0]           claim_id;
   logic [3:0]           winner;
   logic [31:0]          claim_word;
   logic [31:0]          rd_data;
   logic                 unused_dina;

   assign unused_dina  = ^dina;
   assign eligible     = pend & mask & {NUM_SRC{ctrl_en}};
   assign any_eligible = |eligible;
   assign edges        = irq_src & ~prev_src;
   assign claim_read   = !wea && (addra == 4'd2);
   assign eoi_write    = wea && (addra == 4'd3);
   assign w1c_bits     = (wea && (addra == 4'd0)) ? dina[NUM_SRC-1:0] : '0;

   // Scanning from the top down lets the lowest eligible index overwrite the rest.
   always_comb begin
      winner = 4'd0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            winner = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (any_eligible) begin
               state_next = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (!any_eligible) begin
               state_next = ST_IDLE;
            end else if (claim_read) begin
               state_next = ST_SERVICE;
            end
         end
         ST_SERVICE: begin
            if (eoi_write) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // The request line is registered from the next state so it tracks ASSERT exactly.
   always_comb begin
      int_cpu_next = (state_next == ST_ASSERT);
      claim_fire   = (state == ST_ASSERT) && any_eligible && claim_read;
      claim_clr    = claim_fire ? (NUM_SRC'(1) << winner) : '0;
      if (state == ST_SERVICE) begin
         claim_word = {1'b1, 27'd0, claim_id};
      end else if (claim_fire) begin
         claim_word = {1'b1, 27'd0, winner};
      end else begin
         claim_word = 32'd0;
      end
      case (addra)
         4'd0:    rd_data = 32'(pend);
         4'd1:    rd_data = 32'(mask);
         4'd2:    rd_data = claim_word;
         4'd4:    rd_data = {31'd0, ctrl_en};
         default: rd_data = 32'd0;
      endcase
   end

   // A new edge is OR-ed in last so it survives a same-cycle W1C or claim clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend     <= '0;
         mask     <= '0;
         prev_src <= '0;
         ctrl_en  <= 1'b0;
         claim_id <= 4'd0;
         douta    <= 32'd0;
         int_cpu  <= 1'b0;
      end else begin
         prev_src <= irq_src;
         pend     <= (pend & ~w1c_bits & ~claim_clr) | edges;
         douta    <= rd_data;
         int_cpu  <= int_cpu_next;
         if (wea && (addra == 4'd1)) begin
            mask <= dina[NUM_SRC-1:0];
         end
         if (wea && (addra == 4'd4)) begin
            ctrl_en <= dina[0];
         end
         if (claim_fire) begin
            claim_id <= winner;
         end
      end
   end

endmodule

// File: tb/tb_int_ctrl_p.sv
// Self-checking bench for int_ctrl_p: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural model of the controller.
module tb_int_ctrl_p;

   logic        clk;
   logic        rst;
   logic        wea;
   logic [3:0]  addra;
   logic [31:0] dina;
   logic [31:0] douta;
   logic [3:0]  irq_src;
   logic        int_cpu;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0]  m_pend, m_mask, m_prev, m_id;
   logic        m_en, m_req, m_serving;
   logic [31:0] m_douta;

   int_ctrl_p #(.NUM_SRC(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .wea     (wea),
      .addra   (addra),
      .dina    (dina),
      .douta   (douta),
      .irq_src (irq_src),
      .int_cpu (int_cpu)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [3:0] lowest_set(input logic [3:0] v);
      for (int i = 0; i < 4; i++) begin
         if (v[i]) return 4'(i);
      end
      return 4'd0;
   endfunction

   task automatic model_reset();
      m_pend = 0; m_mask = 0; m_prev = 0; m_id = 0;
      m_en = 0; m_req = 0; m_serving = 0; m_douta = 0;
   endtask

   // Applies one access cycle to DUT and model; outputs are sampled 1ns after the edge.
   task automatic drive(input logic we, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] src);
      logic [3:0]  elig, win, n_pend, n_mask, n_id;
      logic        claim, n_en, n_req, n_serv;
      logic [31:0] rd;
      wea = we; addra = a; dina = d; irq_src = src;
      elig  = m_pend & m_mask & {4{m_en}};
      win   = lowest_set(elig);
      claim = m_req && (elig != 0) && !we && (a == 4'd2);
      case (a)
         4'd0: rd = {28'd0, m_pend};
         4'd1: rd = {28'd0, m_mask};
         4'd2: rd = m_serving ? {1'b1, 27'd0, m_id} : (claim ? {1'b1, 27'd0, win} : 32'd0);
         4'd4: rd = {31'd0, m_en};
         default: rd = 32'd0;
      endcase
      n_pend = m_pend & ~((we && a == 4'd0) ? d[3:0] : 4'd0);
      if (claim) n_pend[win] = 1'b0;
      n_pend = n_pend | (src & ~m_prev);
      n_mask = (we && a == 4'd1) ? d[3:0] : m_mask;
      n_en   = (we && a == 4'd4) ? d[0] : m_en;
      n_req = m_req; n_serv = m_serving; n_id = m_id;
      if (m_serving) begin
         if (we && a == 4'd3) n_serv = 1'b0;
      end else if (m_req) begin
         if (elig == 0) n_req = 1'b0;
         else if (claim) begin
            n_req = 1'b0; n_serv = 1'b1; n_id = win;
         end
      end else if (elig != 0) begin
         n_req = 1'b1;
      end
      @(posedge clk);
      #1;
      m_pend = n_pend; m_mask = n_mask; m_en = n_en; m_prev = src;
      m_req = n_req; m_serving = n_serv; m_id = n_id; m_douta = rd;
   endtask

   task automatic test_reset();
      rst = 1'b0; wea = 1'b0; dina = 32'hFFFF_FFFF; irq_src = 4'hF;
      model_reset();
      for (int a = 0; a < 5; a++) begin
         addra = 4'(a);
         @(posedge clk);
         #1;
         n_checks++;
         if (int_cpu !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_int_cpu: got %b expected 0", int_cpu);
         end
         n_checks++;
         if (douta !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_douta addr %0d: got %h expected 0", a, douta);
         end
      end
      irq_src = 4'h0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 4'd0, 32'd0, 4'h0);
         n_checks++;
         if (douta !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL post_reset_pend: got %h expected 0", douta);
         end
      end
   endtask

   task automatic test_basic_claim();
      int waited;
      drive(1'b1, 4'd1, 32'h4, 4'h0);
      drive(1'b1, 4'd4, 32'h1, 4'h0);
      drive(1'b0, 4'd0, 32'd0, 4'b0100);
      waited = 0;
      while (int_cpu !== 1'b1 && waited < 2) begin
         drive(1'b0, 4'd0, 32'd0, 4'h0);
         waited++;
      end
      n_checks++;
      if (int_cpu !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL basic_int_cpu_rise: got %b expected 1", int_cpu);
      end
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h8000_0002) begin
         n_fail++;
         $display("[TB] FAIL basic_claim: got %h expected 80000002", douta);
      end
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'd0 || int_cpu !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_after_claim: pend %h int_cpu %b expected 0/0", douta, int_cpu);
      end
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h8000_0002) begin
         n_fail++;
         $display("[TB] FAIL service_claim_reread: got %h expected 80000002", douta);
      end
      drive(1'b1, 4'd3, 32'd0, 4'h0);
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'd0 || int_cpu !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL basic_after_eoi: claim %h int_cpu %b expected 0/0", douta, int_cpu);
      end
   endtask

   task automatic test_priority();
      drive(1'b1, 4'd1, 32'hF, 4'h0);
      drive(1'b0, 4'd0, 32'd0, 4'b1010);
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      n_checks++;
      if (int_cpu !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL prio_int_cpu: got %b expected 1", int_cpu);
      end
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h8000_0001) begin
         n_fail++;
         $display("[TB] FAIL prio_first_claim: got %h expected 80000001", douta);
      end
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h8) begin
         n_fail++;
         $display("[TB] FAIL prio_pend_left: got %h expected 8", douta);
      end
      drive(1'b1, 4'd3, 32'd0, 4'h0);
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      n_checks++;
      if (int_cpu !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL prio_reassert: got %b expected 1", int_cpu);
      end
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h8000_0003) begin
         n_fail++;
         $display("[TB] FAIL prio_second_claim: got %h expected 80000003", douta);
      end
      drive(1'b1, 4'd3, 32'd0, 4'h0);
   endtask

   task automatic test_masked_latch();
      drive(1'b1, 4'd1, 32'h0, 4'h0);
      drive(1'b0, 4'd0, 32'd0, 4'b0001);
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h1 || int_cpu !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL masked_latch: pend %h int_cpu %b expected 1/0", douta, int_cpu);
      end
      drive(1'b1, 4'd1, 32'h1, 4'h0);
      n_checks++;
      if (int_cpu !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL unmask_early: got %b expected 0", int_cpu);
      end
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      n_checks++;
      if (int_cpu !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL unmask_assert: got %b expected 1", int_cpu);
      end
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h8000_0000) begin
         n_fail++;
         $display("[TB] FAIL unmask_claim: got %h expected 80000000", douta);
      end
      drive(1'b1, 4'd3, 32'd0, 4'h0);
   endtask

   task automatic test_withdrawal();
      drive(1'b1, 4'd1, 32'hF, 4'h0);
      drive(1'b0, 4'd0, 32'd0, 4'b0100);
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      drive(1'b1, 4'd0, 32'h4, 4'h0);
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'd0 || int_cpu !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL withdrawal: claim %h int_cpu %b expected 0/0", douta, int_cpu);
      end
   endtask

   task automatic test_collision();
      drive(1'b1, 4'd0, 32'h4, 4'b0100);
      drive(1'b0, 4'd0, 32'd0, 4'b0100);
      n_checks++;
      if (douta !== 32'h4) begin
         n_fail++;
         $display("[TB] FAIL collision_set_wins: got %h expected 4", douta);
      end
      drive(1'b0, 4'd2, 32'd0, 4'b0100);
      n_checks++;
      if (douta !== 32'h8000_0002) begin
         n_fail++;
         $display("[TB] FAIL collision_claim: got %h expected 80000002", douta);
      end
      drive(1'b1, 4'd3, 32'd0, 4'b0100);
      drive(1'b0, 4'd0, 32'd0, 4'b0100);
      n_checks++;
      if (douta !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL held_no_repend: got %h expected 0", douta);
      end
      drive(1'b0, 4'd0, 32'd0, 4'h0);
   endtask

   task automatic test_mid_reset();
      drive(1'b0, 4'd0, 32'd0, 4'b0010);
      drive(1'b0, 4'd0, 32'd0, 4'h0);
      drive(1'b0, 4'd2, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'h8000_0001) begin
         n_fail++;
         $display("[TB] FAIL midreset_claim: got %h expected 80000001", douta);
      end
      #3;
      rst = 1'b0;
      #1;
      n_checks++;
      if (douta !== 32'd0 || int_cpu !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_async: douta %h int_cpu %b expected 0/0", douta, int_cpu);
      end
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(1'b0, 4'd1, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_mask: got %h expected 0", douta);
      end
      drive(1'b0, 4'd4, 32'd0, 4'h0);
      n_checks++;
      if (douta !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL midreset_ctrl: got %h expected 0", douta);
      end
   endtask

   task automatic test_random();
      logic [3:0]  src, a;
      logic [31:0] d;
      logic        we;
      int          op;
      src = 4'h0;
      drive(1'b1, 4'd4, 32'h1, src);
      for (int n = 0; n < 400; n++) begin
         src = src ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
         op  = $urandom_range(0, 9);
         d   = $urandom;
         we  = 1'b0;
         case (op)
            0, 1: begin we = 1'b1; a = 4'd1; end
            2: begin we = 1'b1; a = 4'd4; d = {31'd0, ($urandom_range(0, 3) != 0)}; end
            3: begin we = 1'b1; a = 4'd0; end
            4: begin we = 1'b1; a = 4'd3; end
            5, 6, 7: a = 4'd2;
            8: a = 4'd0;
            default: begin we = ($urandom_range(0, 1) == 1); a = 4'($urandom_range(3, 15)); end
         endcase
         drive(we, a, d, src);
         n_checks++;
         if (int_cpu !== m_req) begin
            n_fail++;
            $display("[TB] FAIL random_int_cpu cycle %0d: got %b expected %b", n, int_cpu, m_req);
         end
         n_checks++;
         if (douta !== m_douta) begin
            n_fail++;
            $display("[TB] FAIL random_douta cycle %0d addr %0d: got %h expected %h",
                     n, a, douta, m_douta);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_claim();
      test_priority();
      test_masked_latch();
      test_withdrawal();
      test_collision();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
